// File: rtl/video_pkg.sv
// Shared video-subsystem constants: tile-map geometry, tattr DMA register map and FSM encoding.
package video_pkg;

    localparam int unsigned TILES_H    = 25;
    localparam int unsigned TILES_V    = 19;
    localparam int unsigned TATTR_SIZE = 512;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SYNC   = 1;
    localparam int unsigned CTRL_ABORT  = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STAT_SYNC    = 1;
    localparam int unsigned STAT_IRQ_EN  = 3;
    localparam int unsigned STAT_BUSY    = 8;
    localparam int unsigned STAT_DONE    = 9;
    localparam int unsigned STAT_ABORTED = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } dma_state_e;

endpackage

// File: rtl/tattr_dma.sv
// Tile-attribute DMA: copies a byte run from system memory into tattr RAM,
// one byte per bus read, optionally holding new requests off until vblank.
module tattr_dma
    import video_pkg::*;
#(
    parameter int unsigned TATTR_SIZE = video_pkg::TATTR_SIZE,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    cfg_addr,
    input  logic [31:0]                   cfg_wdata,
    input  logic                          cfg_wenable,
    output logic [31:0]                   cfg_rdata,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_ready,
    input  logic [31:0]                   mem_rdata,
    output logic [$clog2(TATTR_SIZE)-1:0] tattr_addr,
    output logic [7:0]                    tattr_wdata,
    output logic                          tattr_wenable,
    input  logic                          vblank,
    output logic                          irq
);

    localparam int unsigned AW = $clog2(TATTR_SIZE);
    localparam int unsigned LW = AW + 1;

    // The whole tile map has to fit in tattr RAM.
    if (TILES_H * TILES_V > TATTR_SIZE) begin : g_map_fits
        $error("tattr RAM smaller than the tile map");
    end

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [AW-1:0]         dst_q;
    logic [LW-1:0]         len_q;
    logic                  sync_q, irq_en_q, done_q, aborted_q, abort_pend_q;
    logic                  mem_req_q, wen_q, irq_q;
    logic [7:0]            byte_q;

    logic busy, reg_wr, ctrl_wr, start_wr, abort_wr, w1c_wr, abort_now;
    logic req_ok, req_ok_start;
    logic req_d, take, step, fin, fin_abort, start_ok, zero_start;

    assign busy         = (state_q != ST_IDLE);
    assign reg_wr       = cfg_wenable && !busy;
    assign ctrl_wr      = cfg_wenable && (cfg_addr == REG_CTRL);
    assign start_wr     = ctrl_wr && cfg_wdata[CTRL_START];
    assign abort_wr     = ctrl_wr && cfg_wdata[CTRL_ABORT];
    assign w1c_wr       = ctrl_wr && cfg_wdata[STAT_DONE];
    assign abort_now    = abort_pend_q || abort_wr;
    assign req_ok       = !sync_q || vblank;
    assign req_ok_start = !cfg_wdata[CTRL_SYNC] || vblank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus one-cycle control strobes for the datapath.
    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        take       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        fin_abort  = 1'b0;
        start_ok   = 1'b0;
        zero_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_wr) begin
                    if (len_q != '0) begin
                        state_d  = ST_REQ;
                        start_ok = 1'b1;
                        req_d    = req_ok_start;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A raised request is held until accepted; abort only bites before it rises.
                if (mem_req_q) begin
                    if (mem_ready) begin
                        state_d = ST_WRITE;
                        take    = 1'b1;
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (abort_now) begin
                    state_d   = ST_IDLE;
                    fin       = 1'b1;
                    fin_abort = 1'b1;
                end else begin
                    req_d = req_ok;
                end
            end
            ST_WRITE: begin
                step = 1'b1;
                if (len_q == LW'(1) || abort_now) begin
                    state_d   = ST_IDLE;
                    fin       = 1'b1;
                    fin_abort = abort_now;
                end else begin
                    state_d = ST_REQ;
                    req_d   = req_ok;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            sync_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            wen_q        <= 1'b0;
            irq_q        <= 1'b0;
            byte_q       <= '0;
        end else begin
            mem_req_q <= req_d;
            wen_q     <= take;
            irq_q     <= done_q & irq_en_q;

            if (take) begin
                byte_q <= mem_rdata[{src_q[1:0], 3'b000} +: 8];
            end

            if (step) begin
                src_q <= src_q + ADDR_WIDTH'(1);
                dst_q <= dst_q + AW'(1);
                len_q <= len_q - LW'(1);
            end else if (reg_wr) begin
                case (cfg_addr)
                    REG_SRC: src_q <= ADDR_WIDTH'(cfg_wdata);
                    REG_DST: dst_q <= AW'(cfg_wdata);
                    REG_LEN: len_q <= (cfg_wdata > 32'(TATTR_SIZE)) ? LW'(TATTR_SIZE)
                                                                   : LW'(cfg_wdata);
                    default: ;
                endcase
            end

            if (ctrl_wr) begin
                irq_en_q <= cfg_wdata[CTRL_IRQ_EN];
                if (!busy) begin
                    sync_q <= cfg_wdata[CTRL_SYNC];
                end
            end

            // Setting done beats a same-cycle W1C.
            if (fin || zero_start) begin
                done_q <= 1'b1;
            end else if (start_ok || w1c_wr) begin
                done_q <= 1'b0;
            end

            if (fin_abort) begin
                aborted_q <= 1'b1;
            end else if (start_ok || zero_start || w1c_wr) begin
                aborted_q <= 1'b0;
            end

            if (fin || !busy) begin
                abort_pend_q <= 1'b0;
            end else if (abort_wr) begin
                abort_pend_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_SRC: cfg_rdata = 32'(src_q);
            REG_DST: cfg_rdata = 32'(dst_q);
            REG_LEN: cfg_rdata = 32'(len_q);
            default: begin
                cfg_rdata[STAT_SYNC]    = sync_q;
                cfg_rdata[STAT_IRQ_EN]  = irq_en_q;
                cfg_rdata[STAT_BUSY]    = busy;
                cfg_rdata[STAT_DONE]    = done_q;
                cfg_rdata[STAT_ABORTED] = aborted_q;
            end
        endcase
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = src_q;
    assign tattr_addr    = dst_q;
    assign tattr_wdata   = byte_q;
    assign tattr_wenable = wen_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_tattr_dma.sv
// Bench for tattr_dma: memory responder, expected-write scoreboard and directed register scenarios.
module tb_tattr_dma;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wenable;
    logic [31:0] cfg_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [8:0]  tattr_addr;
    logic [7:0]  tattr_wdata;
    logic        tattr_wenable;
    logic        vblank;
    logic        irq;

    tattr_dma #(.TATTR_SIZE(512), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wenable(cfg_wenable), .cfg_rdata(cfg_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .tattr_addr(tattr_addr), .tattr_wdata(tattr_wdata), .tattr_wenable(tattr_wenable),
        .vblank(vblank), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [8:0]  dst;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [8:0] log_addr[$];
    logic [7:0] log_data[$];
    int errors = 0, checks = 0;
    int cyc = 0, first_req = -1, last_we = -1, wcount = 0;
    int ready_delay = 0, wait_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // System memory contents; 0x100..0x103 hold the word 0x44332211.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h104) return 8'(32'h11 * (a - 32'hFF));
        return 8'(a * 32'd7) ^ a[15:8];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    task automatic plan(input logic [31:0] src, input int dst, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{src + 32'(i), 9'((dst + i) % 512), mem_byte(src + 32'(i))});
        end
    endtask

    // Bus slave: accepts a request after ready_delay waiting cycles.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF; wait_cnt = 0;
        end else if (wait_cnt >= ready_delay) begin
            mem_ready = 1'b1; mem_rdata = mem_word(mem_addr); wait_cnt = 0;
        end else begin
            mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF; wait_cnt++;
        end
    end

    // Every request must fetch the next planned source byte; every write must match the plan.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst) begin
            if (mem_req) begin
                if (first_req < 0) first_req = cyc;
                chk("req_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("mem_addr", mem_addr, exp_q[0].src);
            end
            if (tattr_wenable) begin
                chk("write_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tattr_addr", 32'(tattr_addr), 32'(e.dst));
                    chk("tattr_wdata", 32'(tattr_wdata), 32'(e.data));
                end
                log_addr.push_back(tattr_addr);
                log_data.push_back(tattr_wdata);
                wcount++;
                last_we = cyc;
            end
        end
    end

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_wenable = 1'b1;
        @(negedge clk);
        cfg_wenable = 1'b0; cfg_wdata = '0;
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] e);
        cfg_addr = a;
        #1;
        chk(nm, cfg_rdata, e);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            cfg_addr = REG_CTRL;
            #1;
            n++;
        end while (cfg_rdata[STAT_BUSY] && n < 2000);
        if (cfg_rdata[STAT_BUSY]) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int w0, n, reqcnt;
        rst = 1'b1; cfg_addr = '0; cfg_wdata = '0; cfg_wenable = 1'b0;
        vblank = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wen", 32'(tattr_wenable), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        expect_reg("rst_src", REG_SRC, 32'd0);
        expect_reg("rst_len", REG_LEN, 32'd0);
        expect_reg("rst_status", REG_CTRL, 32'd0);

        // Basic 4-byte copy from one word, irq enabled.
        @(negedge clk);
        cfg_wr(REG_SRC, 32'h100); cfg_wr(REG_DST, 32'd0); cfg_wr(REG_LEN, 32'd4);
        plan(32'h100, 0, 4);
        log_addr.delete(); log_data.delete(); first_req = -1; ready_delay = 0;
        cfg_wr(REG_CTRL, 32'h9);
        wait_idle("t1");
        chk("t1_status", cfg_rdata, 32'h208);
        chk("t1_nwrites", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            chk("t1_w0", {23'd0, log_addr[0], log_data[0]}, 32'h0011);
            chk("t1_w3", {23'd0, log_addr[3], log_data[3]}, 32'h0344);
        end
        chk("t1_span", 32'(last_we - first_req), 32'd7);
        @(negedge clk);
        chk("t1_irq", 32'(irq), 32'd1);
        expect_reg("t1_src", REG_SRC, 32'h104);
        expect_reg("t1_dst", REG_DST, 32'd4);
        expect_reg("t1_len", REG_LEN, 32'd0);
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);
        @(negedge clk);
        chk("t1_irq_clr", 32'(irq), 32'd0);
        expect_reg("t1_w1c", REG_CTRL, 32'd0);

        // DST wrap, unaligned SRC across a word, DST write ignored while busy.
        @(negedge clk);
        cfg_wr(REG_SRC, 32'h1FE); cfg_wr(REG_DST, 32'd510); cfg_wr(REG_LEN, 32'd4);
        plan(32'h1FE, 510, 4);
        log_addr.delete(); log_data.delete(); ready_delay = 2;
        cfg_wr(REG_CTRL, 32'h1);
        cfg_wr(REG_DST, 32'd5);
        wait_idle("t2");
        chk("t2_nwrites", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            chk("t2_a0", 32'(log_addr[0]), 32'd510);
            chk("t2_a1", 32'(log_addr[1]), 32'd511);
            chk("t2_a2", 32'(log_addr[2]), 32'd0);
            chk("t2_a3", 32'(log_addr[3]), 32'd1);
        end
        expect_reg("t2_dst", REG_DST, 32'd2);
        expect_reg("t2_src", REG_SRC, 32'h202);
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);

        // vblank gating: no request outside vblank, request held once raised.
        cfg_wr(REG_SRC, 32'h200); cfg_wr(REG_DST, 32'd100); cfg_wr(REG_LEN, 32'd2);
        plan(32'h200, 100, 2);
        ready_delay = 1; w0 = wcount; reqcnt = 0; vblank = 1'b0;
        cfg_wr(REG_CTRL, 32'h3);
        for (int i = 0; i < 50; i++) begin
            if (mem_req) reqcnt++;
            @(negedge clk);
        end
        chk("t3_gated", 32'(reqcnt), 32'd0);
        vblank = 1'b1;
        @(negedge clk);
        chk("t3_req_on_vblank", 32'(mem_req), 32'd1);
        vblank = 1'b0;
        @(negedge clk);
        chk("t3_req_held", 32'(mem_req), 32'd1);
        repeat (5) @(negedge clk);
        chk("t3_first_write", 32'(wcount - w0), 32'd1);
        chk("t3_regated", 32'(mem_req), 32'd0);
        vblank = 1'b1;
        wait_idle("t3");
        chk("t3_status", cfg_rdata, 32'h202);
        chk("t3_nwrites", 32'(wcount - w0), 32'd2);
        vblank = 1'b0;
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);

        // Abort while a gated request has not yet risen: no traffic, aborted set.
        cfg_wr(REG_SRC, 32'h500); cfg_wr(REG_DST, 32'd0); cfg_wr(REG_LEN, 32'd3);
        w0 = wcount;
        cfg_wr(REG_CTRL, 32'h3);
        repeat (3) @(negedge clk);
        cfg_wr(REG_CTRL, 32'h6);
        expect_reg("t3b_status", REG_CTRL, 32'h602);
        chk("t3b_nwrites", 32'(wcount - w0), 32'd0);
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);
        expect_reg("t3b_w1c", REG_CTRL, 32'd0);

        // Abort during the 4th request: that byte still lands, then stop.
        @(negedge clk);
        cfg_wr(REG_SRC, 32'h300); cfg_wr(REG_DST, 32'd200); cfg_wr(REG_LEN, 32'd8);
        plan(32'h300, 200, 4);
        ready_delay = 2; w0 = wcount;
        cfg_wr(REG_CTRL, 32'h1);
        n = 0;
        while (!((wcount - w0) == 3 && mem_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reach_req4", 32'(n < 200), 32'd1);
        cfg_wr(REG_CTRL, 32'h4);
        wait_idle("t4");
        chk("t4_status", cfg_rdata, 32'h600);
        chk("t4_nwrites", 32'(wcount - w0), 32'd4);
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);
        expect_reg("t4_w1c", REG_CTRL, 32'd0);

        // Zero length, LEN clamp, start+abort together.
        @(negedge clk);
        w0 = wcount;
        cfg_wr(REG_LEN, 32'd0);
        cfg_wr(REG_CTRL, 32'h1);
        expect_reg("t5_zero_done", REG_CTRL, 32'h200);
        repeat (4) @(negedge clk);
        chk("t5_zero_nwrites", 32'(wcount - w0), 32'd0);
        cfg_wr(REG_CTRL, 32'h200);
        cfg_wr(REG_LEN, 32'd1000);
        expect_reg("t5_len1000", REG_LEN, 32'd512);
        @(negedge clk);
        cfg_wr(REG_LEN, 32'd513);
        expect_reg("t5_len513", REG_LEN, 32'd512);
        @(negedge clk);
        cfg_wr(REG_LEN, 32'd512);
        expect_reg("t5_len512", REG_LEN, 32'd512);
        @(negedge clk);
        cfg_wr(REG_SRC, 32'h600); cfg_wr(REG_DST, 32'd50); cfg_wr(REG_LEN, 32'd1);
        plan(32'h600, 50, 1);
        ready_delay = 0; w0 = wcount;
        cfg_wr(REG_CTRL, 32'h5);
        wait_idle("t5b");
        chk("t5b_status", cfg_rdata, 32'h200);
        chk("t5b_nwrites", 32'(wcount - w0), 32'd1);
        @(negedge clk);
        cfg_wr(REG_CTRL, 32'h200);

        // Reset while a request is stalled.
        cfg_wr(REG_SRC, 32'h400); cfg_wr(REG_DST, 32'd0); cfg_wr(REG_LEN, 32'd2);
        plan(32'h400, 0, 2);
        ready_delay = 100000;
        cfg_wr(REG_CTRL, 32'h9);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_req_up", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_req_drop", 32'(mem_req), 32'd0);
        chk("t6_wen_drop", 32'(tattr_wenable), 32'd0);
        exp_q.delete();
        ready_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        expect_reg("t6_status", REG_CTRL, 32'd0);
        expect_reg("t6_src", REG_SRC, 32'd0);
        expect_reg("t6_len", REG_LEN, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_irq", 32'(irq), 32'd0);
        chk("end_plan_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
